time_set_control: RTL
=====================

# time_set_control

Parametrised successor to the clock-setting control block. It edge-detects the Set/Load/Start/Stop push buttons and enters a six-digit BCD hh:mm:ss time one digit per Set press from a 4-bit switch group. Each digit is clamped to a legal value for 12 h or 24 h mode, and the time is committed atomically once all six digits are entered. It also latches a patient ID for the ROM and reports the run/stop state to the timer datapath that follows it.

## Interface
Parameters:
- MODE24, 0: 0 = 12 h clock (01:00:00–12:59:59); 1 = 24 h clock (00:00:00–23:59:59)
- RESET_TIME, 24'h125959: BCD time loaded on reset; must be legal for MODE24
- ID_WIDTH, 8: patient ID / ROM address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetN  in  1  synchronous, active-low reset
- btnSet, btnLoad, btnStart, btnStop  in  1 each  debounced, synchronised push-button levels
- digitIn  in  4  switch value for the digit being set
- idIn  in  ID_WIDTH  patient ID switches
- timeOut  out  24  committed BCD time {HT,HU,MT,MU,ST,SU}; reset RESET_TIME
- timeValid  out  1  one-cycle pulse when a new time commits; reset 0
- romAddr  out  ID_WIDTH  latched patient ID; reset 0
- romReq  out  1  one-cycle ROM read strobe; reset 0
- state  out  3  IDLE=0, SET=1, LOAD=2, RUN=3, STOP=4; reset IDLE
- digitIdx  out  3  next digit to set, 0=HT … 5=SU; reset 0

## Operation
- Edge detect: press = btn & ~btnQ. btnQ resets to all ones, so a button held through reset does not fire until it is released and pressed again.
- Simultaneous presses: priority is Stop > Start > Load > Set; only the winner acts.
- IDLE/LOAD:
  - Set: commit digitIn to shadow digit 0, go to SET, digitIdx=1.
  - Load: romAddr<=idIn, romReq pulse, go to LOAD.
  - Start: go to RUN.
  - Stop: ignored.
- SET:
  - Set: clamp digitIn into shadow[digitIdx], digitIdx+1.
  - On the digit-5 press: timeOut<=shadow (including this digit), timeValid pulse, digitIdx<=0, go to IDLE.
  - Stop: discard shadow, digitIdx<=0, go to IDLE; timeOut is unchanged.
  - Start and Load: ignored.
- RUN:
  - Stop: go to STOP.
  - Set, Load, Start: ignored (lockout).
- STOP:
  - Start: go to RUN.
  - Set and Load: act as in IDLE.
- Clamp rules (value above max becomes max):
  - HT: max 1 (12 h) / 2 (24 h).
  - HU, 12 h: with HT=0, legal range 1–9 (0 becomes 1, above 9 becomes 9). With HT=1, max 2.
  - HU, 24 h: max 9 with HT<2; max 3 with HT=2.
  - MT and ST: max 5. MU and SU: max 9.
  - HU is checked against the HT already held in shadow.
- The shadow register is not visible on timeOut until commit.

## Timing
- Button sampled high at edge n (low at n-1): state, digitIdx, romAddr and timeOut update at edge n. timeValid and romReq are high for the cycle following edge n.
- Button held: exactly one action per press.
- Reset asserted in any state: all outputs return to their reset values at the next edge, and any partial entry is discarded.

## Structure
- Package time_ctrl_pkg holds:
  - state encodings IDLE/SET/LOAD/RUN/STOP;
  - digit index constants DIG_HT..DIG_SU;
  - BCD max constants (1, 2, 3, 5, 9).
- Sub-module bcd_digit_clamp: combinational; inputs digit index, raw value, shadow HT, MODE24; output clamped BCD digit.
- Top level holds the edge detect, FSM, shadow register and output registers.

## Test plan
- Reset, MODE24=0: timeOut=12:59:59, state=0, digitIdx=0. A Set held through reset release produces no action.
- 12 h entry with switch values F,7,9,F,3,A: timeOut=12:59:39 (HT 1, HU clamped to 2, MT 5, MU 9, ST 3, SU 9). timeValid pulses once, only after the sixth press.
- MODE24=1 entry with 2,7,0,0,0,0: timeOut=23:00:00. Entry with 0,0,…: timeOut=00:00:00, and 12 h mode yields 01:00:00.
- Stop after three digits: state=IDLE, timeOut unchanged, digitIdx=0, no timeValid.
- Start then Set/Load presses: state stays RUN and romReq stays 0. Stop gives STOP; Load with idIn=8'h2A gives romAddr=2A, a one-cycle romReq, state=LOAD.
- Stop and Set on the same cycle in SET: abort wins. Start and Load together from IDLE: RUN, romReq=0.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// Shared encodings, digit indices, BCD limits and small helpers for the
// clock-setting control block.
package time_ctrl_pkg;

    // Controller states, visible on the state port as their numeric codes.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SET  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        STOP = 3'd4
    } ctrl_state_t;

    // The single button action that wins arbitration in a given cycle.
    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_SET   = 3'd1,
        ACT_LOAD  = 3'd2,
        ACT_START = 3'd3,
        ACT_STOP  = 3'd4
    } btn_action_t;

    // Digit positions within {HT,HU,MT,MU,ST,SU}, in entry order.
    localparam logic [2:0] DIG_HT = 3'd0;
    localparam logic [2:0] DIG_HU = 3'd1;
    localparam logic [2:0] DIG_MT = 3'd2;
    localparam logic [2:0] DIG_MU = 3'd3;
    localparam logic [2:0] DIG_ST = 3'd4;
    localparam logic [2:0] DIG_SU = 3'd5;

    // Upper limits used by the digit clamp.
    localparam logic [3:0] BCD_MAX_1 = 4'd1;
    localparam logic [3:0] BCD_MAX_2 = 4'd2;
    localparam logic [3:0] BCD_MAX_3 = 4'd3;
    localparam logic [3:0] BCD_MAX_5 = 4'd5;
    localparam logic [3:0] BCD_MAX_9 = 4'd9;

    // Saturate a raw switch value at a digit maximum.
    function automatic logic [3:0] bcd_min(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    // Pick the winning press; press bits are {stop, start, load, set}.
    function automatic btn_action_t pick_action(input logic [3:0] press);
        if (press[3])      return ACT_STOP;
        else if (press[2]) return ACT_START;
        else if (press[1]) return ACT_LOAD;
        else if (press[0]) return ACT_SET;
        else               return ACT_NONE;
    endfunction

    // Replace one BCD digit of a packed hh:mm:ss word.
    function automatic logic [23:0] put_digit(input logic [23:0] w,
                                              input logic [2:0]  idx,
                                              input logic [3:0]  v);
        logic [23:0] r;
        r = w;
        case (idx)
            DIG_HT:  r[23:20] = v;
            DIG_HU:  r[19:16] = v;
            DIG_MT:  r[15:12] = v;
            DIG_MU:  r[11:8]  = v;
            DIG_ST:  r[7:4]   = v;
            DIG_SU:  r[3:0]   = v;
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_clamp.sv
// Combinational clamp that forces a switch value into the legal range of the
// digit being entered, for either the 12 h or the 24 h clock.
module bcd_digit_clamp
    import time_ctrl_pkg::*;
#(
    parameter bit MODE24 = 1'b0
) (
    input  logic [2:0] idx,
    input  logic [3:0] raw,
    input  logic [3:0] shadow_ht,
    output logic [3:0] clamped
);

    // Choose the limit for this digit position; HU depends on the held HT.
    always_comb begin
        clamped = bcd_min(raw, BCD_MAX_9);
        case (idx)
            DIG_HT: begin
                clamped = bcd_min(raw, MODE24 ? BCD_MAX_2 : BCD_MAX_1);
            end
            DIG_HU: begin
                if (MODE24) begin
                    clamped = bcd_min(raw, (shadow_ht == BCD_MAX_2) ? BCD_MAX_3 : BCD_MAX_9);
                end else if (shadow_ht == 4'd0) begin
                    // 12 h hours never read 00, so 0x becomes 01.
                    clamped = (raw == 4'd0) ? 4'd1 : bcd_min(raw, BCD_MAX_9);
                end else begin
                    clamped = bcd_min(raw, BCD_MAX_2);
                end
            end
            DIG_MT, DIG_ST: begin
                clamped = bcd_min(raw, BCD_MAX_5);
            end
            default: begin
                clamped = bcd_min(raw, BCD_MAX_9);
            end
        endcase
    end

endmodule

// File: rtl/time_set_control.sv
// Clock-setting controller: button edge detect with priority arbitration,
// digit-by-digit BCD time entry into a shadow register with atomic commit,
// patient ID latch with ROM strobe, and run/stop reporting.
module time_set_control
    import time_ctrl_pkg::*;
#(
    parameter bit          MODE24     = 1'b0,
    parameter logic [23:0] RESET_TIME = 24'h125959,
    parameter int          ID_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                btnSet,
    input  logic                btnLoad,
    input  logic                btnStart,
    input  logic                btnStop,
    input  logic [3:0]          digitIn,
    input  logic [ID_WIDTH-1:0] idIn,
    output logic [23:0]         timeOut,
    output logic                timeValid,
    output logic [ID_WIDTH-1:0] romAddr,
    output logic                romReq,
    output logic [2:0]          state,
    output logic [2:0]          digitIdx
);

    logic [3:0]          btn_now;
    logic [3:0]          btn_q;
    logic [3:0]          press;
    btn_action_t         action;

    ctrl_state_t         state_q, state_d;
    logic [2:0]          idx_d;
    logic [23:0]         shadow_q, shadow_d;
    logic [23:0]         time_d;
    logic [ID_WIDTH-1:0] addr_d;
    logic                valid_d;
    logic                req_d;

    logic [2:0]          wr_idx;
    logic [3:0]          clamped;

    assign btn_now = {btnStop, btnStart, btnLoad, btnSet};
    assign press   = btn_now & ~btn_q;
    assign action  = pick_action(press);
    assign state   = state_q;

    // Outside SET a Set press always starts a fresh entry at HT.
    assign wr_idx = (state_q == SET) ? digitIdx : DIG_HT;

    bcd_digit_clamp #(
        .MODE24 (MODE24)
    ) u_clamp (
        .idx       (wr_idx),
        .raw       (digitIn),
        .shadow_ht (shadow_q[23:20]),
        .clamped   (clamped)
    );

    // Previous button levels; all ones so a button held through reset is inert.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            btn_q <= 4'hF;
        end else begin
            btn_q <= btn_now;
        end
    end

    // Next-state and register-update decisions for the winning press.
    always_comb begin
        state_d  = state_q;
        idx_d    = digitIdx;
        shadow_d = shadow_q;
        time_d   = timeOut;
        addr_d   = romAddr;
        valid_d  = 1'b0;
        req_d    = 1'b0;
        case (state_q)
            IDLE, LOAD, STOP: begin
                case (action)
                    ACT_SET: begin
                        shadow_d = put_digit(shadow_q, DIG_HT, clamped);
                        idx_d    = DIG_HU;
                        state_d  = SET;
                    end
                    ACT_LOAD: begin
                        addr_d  = idIn;
                        req_d   = 1'b1;
                        state_d = LOAD;
                    end
                    ACT_START: begin
                        state_d = RUN;
                    end
                    default: begin
                    end
                endcase
            end
            SET: begin
                case (action)
                    ACT_SET: begin
                        shadow_d = put_digit(shadow_q, digitIdx, clamped);
                        if (digitIdx == DIG_SU) begin
                            time_d  = shadow_d;
                            valid_d = 1'b1;
                            idx_d   = DIG_HT;
                            state_d = IDLE;
                        end else begin
                            idx_d = digitIdx + 3'd1;
                        end
                    end
                    ACT_STOP: begin
                        idx_d   = DIG_HT;
                        state_d = IDLE;
                    end
                    default: begin
                    end
                endcase
            end
            RUN: begin
                if (action == ACT_STOP) begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial entry.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            digitIdx  <= DIG_HT;
            timeOut   <= RESET_TIME;
            timeValid <= 1'b0;
            romAddr   <= '0;
            romReq    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digitIdx  <= idx_d;
            timeOut   <= time_d;
            timeValid <= valid_d;
            romAddr   <= addr_d;
            romReq    <= req_d;
        end
    end

    // Shadow digits are only read after being written in the same entry.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

endmodule
